// File: rtl/processor_pkg.sv
// Shared definitions for the program loader: loader state encoding and default widths.
package processor_pkg;

  localparam int INSTR_W_DEF = 8;
  localparam int ADDR_W_DEF  = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN   = 3'd1,
    ST_DATA  = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERR   = 3'd5
  } state_t;

endpackage

// File: rtl/program_loader.sv
// Loads a length-prefixed, XOR-checksummed program from a host byte stream into
// program memory and releases the processor only after a verified load.
module program_loader
  import processor_pkg::*;
#(
  parameter int INSTR_W = INSTR_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               in_valid,
  input  logic [INSTR_W-1:0] in_data,
  output logic               in_ready,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [INSTR_W-1:0] mem_wdata,
  output logic               cpu_run,
  output logic               busy,
  output logic               error
);

  localparam int DEPTH = 2**ADDR_W;

  state_t             state, state_nxt;
  logic [ADDR_W:0]    cnt;
  logic [ADDR_W:0]    cnt_inc;
  logic [ADDR_W:0]    len;
  logic [INSTR_W-1:0] acc;
  logic               accept;
  logic               len_ok;
  logic               can_start;

  always_comb begin
    in_ready  = (state == ST_LEN) || (state == ST_DATA) || (state == ST_CHECK);
    busy      = in_ready;
    cpu_run   = (state == ST_DONE);
    error     = (state == ST_ERR);
    can_start = (state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR);
    accept    = in_valid & in_ready;
    len_ok    = (in_data != '0) && (in_data <= INSTR_W'(DEPTH));
    cnt_inc   = cnt + 1'b1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE, ST_ERR: if (start) state_nxt = ST_LEN;
      ST_LEN:   if (accept) state_nxt = len_ok ? ST_DATA : ST_ERR;
      ST_DATA:  if (accept && (cnt_inc == len)) state_nxt = ST_CHECK;
      ST_CHECK: if (accept) state_nxt = (in_data == acc) ? ST_DONE : ST_ERR;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // counter stops at len, so the address never wraps past N-1
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      len       <= '0;
      acc       <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state  <= state_nxt;
      mem_we <= 1'b0;
      if (can_start && start) begin
        cnt <= '0;
        acc <= '0;
      end
      if ((state == ST_LEN) && accept && len_ok)
        len <= (ADDR_W+1)'(in_data);
      if ((state == ST_DATA) && accept) begin
        mem_we    <= 1'b1;
        mem_addr  <= cnt[ADDR_W-1:0];
        mem_wdata <= in_data;
        acc       <= acc ^ in_data;
        cnt       <= cnt_inc;
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: expected memory writes are queued by the
// stimulus and consumed by an independent write monitor.
module tb_program_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic       mem_we;
  logic [1:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       cpu_run;
  logic       busy;
  logic       error;

  int vectors = 0;
  int miscompares = 0;
  int wcount = 0;
  int w0;
  logic [9:0] sb[$];

  program_loader #(.INSTR_W(8), .ADDR_W(2)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_run(cpu_run), .busy(busy), .error(error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // write monitor: every mem_we must match the oldest queued expectation
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wcount++;
      if (sb.size() == 0) begin
        check("unexpected_write", {22'd0, mem_addr, mem_wdata}, 32'h3ff);
      end else begin
        logic [9:0] e;
        e = sb.pop_front();
        check("write_addr_data", {22'd0, mem_addr, mem_wdata}, {22'd0, e});
      end
    end
  end

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
  endtask

  task automatic send_data(input logic [1:0] a, input logic [7:0] b);
    sb.push_back({a, b});
    send(b);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    check({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
    check({tag, "_mem_addr"}, {30'd0, mem_addr}, 32'd0);
    check({tag, "_mem_wdata"}, {24'd0, mem_wdata}, 32'd0);
    check({tag, "_cpu_run"}, {31'd0, cpu_run}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_error"}, {31'd0, error}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // N=3 good load
    do_start();
    check("start_busy", {31'd0, busy}, 32'd1);
    check("start_ready", {31'd0, in_ready}, 32'd1);
    send(8'd3);
    send_data(2'd0, 8'h21);
    send_data(2'd1, 8'h4A);
    send_data(2'd2, 8'h13);
    send(8'h78);
    idle();
    check("n3_cpu_run", {31'd0, cpu_run}, 32'd1);
    check("n3_busy", {31'd0, busy}, 32'd0);
    check("n3_error", {31'd0, error}, 32'd0);
    check("n3_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    check("n3_sb_empty", sb.size(), 32'd0);

    // length 0 and length 5
    w0 = wcount;
    do_start();
    check("restart_cpu_run", {31'd0, cpu_run}, 32'd0);
    send(8'd0);
    idle();
    check("len0_error", {31'd0, error}, 32'd1);
    check("len0_cpu_run", {31'd0, cpu_run}, 32'd0);
    check("len0_busy", {31'd0, busy}, 32'd0);
    do_start();
    check("start_clears_error", {31'd0, error}, 32'd0);
    send(8'd5);
    idle();
    check("len5_error", {31'd0, error}, 32'd1);
    @(negedge clk);
    check("len_err_no_writes", wcount - w0, 32'd0);

    // N=2 with bad checksum
    do_start();
    send(8'd2);
    send_data(2'd0, 8'h11);
    send_data(2'd1, 8'h22);
    send(8'h00);
    idle();
    check("badchk_error", {31'd0, error}, 32'd1);
    check("badchk_cpu_run", {31'd0, cpu_run}, 32'd0);
    @(negedge clk);
    check("badchk_sb_empty", sb.size(), 32'd0);

    // N=4 with in_valid toggling
    do_start();
    send(8'd4);
    for (int i = 0; i < 4; i++) begin
      send_data(2'(i), 8'(1 << i));
      in_valid = 1'b0;
      in_data  = 8'hFF;
      @(negedge clk);
      check("stall_busy", {31'd0, busy}, 32'd1);
    end
    send(8'h0F);
    idle();
    check("n4_cpu_run", {31'd0, cpu_run}, 32'd1);
    @(negedge clk);
    check("n4_sb_empty", sb.size(), 32'd0);

    // start in DONE restarts; start during DATA ignored
    do_start();
    check("done_start_cpu_run", {31'd0, cpu_run}, 32'd0);
    check("done_start_ready", {31'd0, in_ready}, 32'd1);
    send(8'd2);
    send_data(2'd0, 8'hA5);
    idle();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("data_start_busy", {31'd0, busy}, 32'd1);
    send_data(2'd1, 8'h5A);
    send(8'hFF);
    idle();
    check("data_start_cpu_run", {31'd0, cpu_run}, 32'd1);
    check("data_start_error", {31'd0, error}, 32'd0);

    // reset mid-session overrides start and in_valid
    do_start();
    send(8'd4);
    send_data(2'd0, 8'h31);
    send_data(2'd1, 8'h32);
    rst = 1'b1;
    start = 1'b1;
    in_valid = 1'b1;
    in_data = 8'h33;
    @(negedge clk);
    check_all_zero("midrst");
    rst = 1'b0;
    start = 1'b0;
    idle();
    w0 = wcount;
    repeat (3) @(negedge clk);
    check("midrst_no_writes", wcount - w0, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("final_sb_empty", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter: INSTR_W, 8, instruction width in bits.
REQ-002 Parameter: ADDR_W, 2, program memory address width; depth = 2**ADDR_W = 4 words.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to begin a load session.
REQ-006 in_valid  input  1  host byte valid.
REQ-007 in_data  input  INSTR_W  host byte (length, instruction or checksum).
REQ-008 in_ready  output  1  loader accepts a byte this cycle.
REQ-009 mem_we  output  1  program memory write strobe.
REQ-010 mem_addr  output  ADDR_W  program memory write address.
REQ-011 mem_wdata  output  INSTR_W  program memory write data.
REQ-012 cpu_run  output  1  processor may fetch/execute; low while loading.
REQ-013 busy  output  1  session in progress (states LEN, DATA, CHECK).
REQ-014 error  output  1  last session failed; sticky until next start or rst.

Function
REQ-015 FSM states SHALL be IDLE, LEN, DATA, CHECK, DONE, ERR.
REQ-016 Byte accepted only on cycle where in_valid and in_ready are both high.
REQ-017 in_ready SHALL be high exactly in LEN, DATA, CHECK; low elsewhere, independent of in_valid.
REQ-018 IDLE/DONE/ERR: start -> LEN next cycle; clears error, cpu_run, word counter, checksum accumulator.
REQ-019 start SHALL be ignored in LEN, DATA, CHECK.
REQ-020 LEN: accepted byte N; N in 1..4 -> latch N, go DATA; N = 0 or N > 4 -> ERR.
REQ-021 DATA: each accepted byte written to address = word counter; counter increments; accumulator XOR= byte; after Nth byte -> CHECK.
REQ-022 Writes registered: mem_we, mem_addr, mem_wdata valid on the cycle after acceptance; mem_we one cycle per byte; no write for length or checksum bytes.
REQ-023 CHECK: accepted byte equal to accumulator -> DONE; otherwise -> ERR.
REQ-024 DONE: cpu_run = 1; ERR: error = 1, cpu_run = 0.
REQ-025 Words beyond N SHALL not be written; prior contents retained.
REQ-026 Word counter SHALL never wrap; max written address = N-1.
REQ-027 in_valid low stalls any state indefinitely with no state change.
REQ-028 Back-to-back acceptance (in_valid held high) SHALL sustain one byte per cycle.

Reset
REQ-029 rst SHALL override all inputs, including start, on the same edge.
REQ-030 After rst: state IDLE, in_ready 0, mem_we 0, mem_addr 0, mem_wdata 0, cpu_run 0, busy 0, error 0, counters 0.
REQ-031 rst mid-session SHALL abort with no further mem_we; partially written words remain in memory.

Structure
REQ-032 State encoding, INSTR_W and ADDR_W defaults SHALL live in a shared package processor_pkg.
REQ-033 Single module, no sub-modules; FSM, counter and XOR accumulator in one sequential block plus combinational decode of in_ready/busy.

Verification
REQ-034 Load N=3 bytes 0x21,0x4A,0x13, checksum 0x78 -> mem_we pulses at addr 0,1,2 with those data; DONE; cpu_run = 1.
REQ-035 Length 0x00 and length 0x05 -> ERR, error = 1, no mem_we.
REQ-036 N=2 bytes 0x11,0x22, checksum 0x00 -> both writes occur, ERR, cpu_run = 0.
REQ-037 N=4 with in_valid toggled 1,0,1,0 -> writes only on accepted cycles, addr 0..3 in order, no wrap.
REQ-038 rst asserted after second data byte of N=4 session -> next cycle all outputs at reset values, no further writes.
REQ-039 start pulsed during DATA -> ignored; start in DONE -> cpu_run drops next cycle, state LEN.
